flit_out_arb: RTL and testbench

Round-robin arbiter that shares a node's single router-facing flit output port between NR flit sources, e.g. the spike/config output path and a config read-reply path. It owns the port's credit counter and grants at most one flit per cycle, only when a downstream credit is available. Multi-flit DATA packets are locked to one source until their DATA_END flit, so packets from different sources never interleave. It sits between the per-node flit producers and the node-top router interface.

---
 rtl/flit_out_arb_if.sv | 23 ++
 rtl/flit_out_arb.sv | 160 ++++++++++++++++
 tb/tb_flit_out_arb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/flit_out_arb_if.sv
// Requester-side and router-side flit handshake of the output arbiter.
// The environment is master; flit_out_arb is slave.
interface flit_out_arb_if #(
  parameter int NR = 2,
  parameter int FW = 59
);
  logic [NR-1:0]    req_valid;
  logic [NR*FW-1:0] req_flit;
  logic [NR-1:0]    req_ready;
  logic             credit_in;
  logic             flit_out_wr;
  logic [FW-1:0]    flit_out;

  modport master (
    output req_valid, req_flit, credit_in,
    input  req_ready, flit_out_wr, flit_out
  );

  modport slave (
    input  req_valid, req_flit, credit_in,
    output req_ready, flit_out_wr, flit_out
  );
endinterface

// File: rtl/flit_out_arb.sv
// Round-robin, credit-gated arbiter for a node's single router-facing flit port.
// DATA packets lock the port to one source until their terminating flit.

// Per-requester decode: eligibility for a grant this cycle and DATA detection.
module flit_out_arb_lane #(
  parameter int FTW = 3
) (
  input  logic [FTW-1:0] ftype,
  input  logic           valid,
  input  logic           locked,
  input  logic           is_owner,
  input  logic           avail,
  output logic           elig,
  output logic           is_data
);
  localparam logic [FTW-1:0] T_DATA = FTW'(1);

  assign is_data = (ftype == T_DATA);
  assign elig    = valid & avail & (~locked | is_owner);
endmodule

module flit_out_arb #(
  parameter int NR      = 2,
  parameter int FW      = 59,
  parameter int FTW     = 3,
  parameter int B       = 4,
  parameter int CREDITS = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  flit_out_arb_if.slave   bus,
  output logic [B-1:0]    credit_cnt,
  output logic            busy,
  output logic            err_credit
);
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [B-1:0] CRED_MAX = B'(CREDITS);

  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [B-1:0]   cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [FW-1:0]  flit_q, flit_d;
  logic           err_q, err_d;

  logic [NR-1:0][FW-1:0] flit_arr;
  logic [NR-1:0]         elig;
  logic [NR-1:0]         is_data;
  logic [NR-1:0]         gnt;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         nxt_ptr;
  logic                  xfer;
  logic                  avail;
  logic                  locked;

  assign avail  = (cnt_q != '0);
  assign locked = (state_q == S_LOCK);

  for (genvar i = 0; i < NR; i++) begin : g_lane
    assign flit_arr[i] = bus.req_flit[i*FW +: FW];

    flit_out_arb_lane #(.FTW(FTW)) u_lane (
      .ftype    (flit_arr[i][FW-1 -: FTW]),
      .valid    (bus.req_valid[i]),
      .locked   (locked),
      .is_owner (owner_q == PW'(i)),
      .avail    (avail),
      .elig     (elig[i]),
      .is_data  (is_data[i])
    );
  end

  // Rotating-priority search; in S_LOCK only the owner can be eligible.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    for (int k = 0; k < NR; k++) begin
      idx = (int'(rr_ptr_q) + k) % NR;
      if (!xfer && elig[idx]) begin
        xfer     = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

  assign nxt_ptr = (gnt_idx == PW'(NR-1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = xfer;
    flit_d   = xfer ? flit_arr[gnt_idx] : flit_q;

    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          rr_ptr_d = nxt_ptr;
          if (is_data[gnt_idx]) begin
            state_d = S_LOCK;
            owner_d = gnt_idx;
          end
        end
        S_LOCK: begin
          // gnt_idx is the owner here; rr_ptr moves only when the packet ends
          if (!is_data[gnt_idx]) begin
            state_d  = S_IDLE;
            rr_ptr_d = nxt_ptr;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case ({xfer, bus.credit_in})
      2'b10: cnt_d = cnt_q - B'(1);
      2'b01: begin
        if (cnt_q == CRED_MAX) err_d = 1'b1;
        else                   cnt_d = cnt_q + B'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= CRED_MAX;
      wr_q     <= 1'b0;
      flit_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      flit_q   <= flit_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.flit_out_wr = wr_q;
  assign bus.flit_out    = flit_q;
  assign credit_cnt      = cnt_q;
  assign busy            = (state_q == S_LOCK);
  assign err_credit      = err_q;
endmodule

// File: tb/tb_flit_out_arb.sv
// Directed bench for flit_out_arb: reset, round-robin, packet lock, credits,
// credit overflow error and reset during a locked packet.
module tb_flit_out_arb;
  localparam int NR = 2, FW = 59, FTW = 3, B = 4, CREDITS = 15;
  localparam logic [2:0] T_SPIKE = 3'b000, T_DATA = 3'b001, T_END = 3'b010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [B-1:0] credit_cnt;
  logic         busy, err_credit;
  int           total = 0;
  int           bad = 0;

  flit_out_arb_if #(.NR(NR), .FW(FW)) bus ();

  flit_out_arb #(.NR(NR), .FW(FW), .FTW(FTW), .B(B), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [2:0] t, input int p);
    return {t, 56'(p)};
  endfunction

  task automatic setf(input int i, input logic [FW-1:0] f);
    bus.req_flit[i*FW +: FW] = f;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrs;
    int n;
    bus.req_valid = '0;
    bus.req_flit  = '0;
    bus.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 64'(credit_cnt), 64'd15);
    chk("rst_flit", 64'(bus.flit_out), 64'd0);
    chk("rst_wr", 64'(bus.flit_out_wr), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_credit), 64'd0);
    rst_n = 1'b1;

    wrs = 0;
    repeat (10) begin
      next();
      if (bus.flit_out_wr) wrs++;
    end
    chk("idle_wr", 64'(wrs), 64'd0);

    // round robin with a credit returned every cycle
    bus.req_valid = 2'b11;
    bus.credit_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      setf(0, mk(T_SPIKE, 16 + k));
      setf(1, mk(T_SPIKE, 32 + k));
      #1;
      chk("rr_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      next();
      chk("rr_flit", 64'(bus.flit_out),
          (k % 2 == 0) ? 64'(mk(T_SPIKE, 16 + k)) : 64'(mk(T_SPIKE, 32 + k)));
      chk("rr_wr", 64'(bus.flit_out_wr), 64'd1);
      chk("rr_cnt", 64'(credit_cnt), 64'd15);
    end
    bus.req_valid = 2'b00;
    bus.credit_in = 1'b0;
    next();
    chk("rr_stop_wr", 64'(bus.flit_out_wr), 64'd0);

    // packet lock with a gap in the owner's valid
    bus.req_valid = 2'b11;
    setf(1, mk(T_SPIKE, 'h55));
    setf(0, mk(T_DATA, 1));
    #1 chk("lk_ready0", 64'(bus.req_ready), 64'd1);
    next();
    chk("lk_busy0", 64'(busy), 64'd1);
    chk("lk_flit0", 64'(bus.flit_out), 64'(mk(T_DATA, 1)));
    bus.req_valid = 2'b10;
    #1 chk("lk_gap1", 64'(bus.req_ready), 64'd0);
    next();
    chk("lk_gap_busy", 64'(busy), 64'd1);
    chk("lk_gap_wr", 64'(bus.flit_out_wr), 64'd0);
    #1 chk("lk_gap2", 64'(bus.req_ready), 64'd0);
    next();
    bus.req_valid = 2'b11;
    setf(0, mk(T_DATA, 2));
    #1 chk("lk_ready1", 64'(bus.req_ready), 64'd1);
    next();
    chk("lk_flit1", 64'(bus.flit_out), 64'(mk(T_DATA, 2)));
    chk("lk_busy1", 64'(busy), 64'd1);
    setf(0, mk(T_END, 3));
    #1 chk("lk_ready2", 64'(bus.req_ready), 64'd1);
    next();
    chk("lk_end_busy", 64'(busy), 64'd0);
    chk("lk_end_flit", 64'(bus.flit_out), 64'(mk(T_END, 3)));
    bus.req_valid = 2'b10;
    #1 chk("lk_src1", 64'(bus.req_ready), 64'd2);
    next();
    chk("lk_src1_flit", 64'(bus.flit_out), 64'(mk(T_SPIKE, 'h55)));
    bus.req_valid = 2'b00;
    chk("lk_cnt", 64'(credit_cnt), 64'd11);
    bus.credit_in = 1'b1;
    repeat (4) next();
    bus.credit_in = 1'b0;
    chk("refill_cnt", 64'(credit_cnt), 64'd15);
    chk("refill_err", 64'(err_credit), 64'd0);

    // credit exhaustion
    bus.req_valid = 2'b01;
    setf(0, mk(T_SPIKE, 7));
    n = 0;
    repeat (16) begin
      #1;
      if (bus.req_ready[0]) n++;
      next();
    end
    chk("ex_grants", 64'(n), 64'd15);
    chk("ex_cnt", 64'(credit_cnt), 64'd0);
    #1 chk("ex_ready", 64'(bus.req_ready), 64'd0);
    bus.credit_in = 1'b1;
    #1 chk("ex_same_cycle", 64'(bus.req_ready), 64'd0);
    next();
    bus.credit_in = 1'b0;
    chk("ex_cnt1", 64'(credit_cnt), 64'd1);
    #1 chk("ex_ready1", 64'(bus.req_ready), 64'd1);
    next();
    chk("ex_wr1", 64'(bus.flit_out_wr), 64'd1);
    chk("ex_cnt0", 64'(credit_cnt), 64'd0);
    #1 chk("ex_ready0", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 2'b00;
    next();
    chk("ex_wr0", 64'(bus.flit_out_wr), 64'd0);

    // simultaneous credit and transfer, then overflow error
    bus.credit_in = 1'b1;
    repeat (3) next();
    bus.credit_in = 1'b0;
    chk("sim_cnt_pre", 64'(credit_cnt), 64'd3);
    bus.req_valid = 2'b01;
    bus.credit_in = 1'b1;
    #1 chk("sim_ready", 64'(bus.req_ready), 64'd1);
    next();
    bus.req_valid = 2'b00;
    bus.credit_in = 1'b0;
    chk("sim_cnt", 64'(credit_cnt), 64'd3);
    chk("sim_wr", 64'(bus.flit_out_wr), 64'd1);
    bus.credit_in = 1'b1;
    repeat (12) next();
    bus.credit_in = 1'b0;
    chk("ov_cnt_pre", 64'(credit_cnt), 64'd15);
    chk("ov_err_pre", 64'(err_credit), 64'd0);
    bus.credit_in = 1'b1;
    next();
    bus.credit_in = 1'b0;
    chk("ov_cnt", 64'(credit_cnt), 64'd15);
    chk("ov_err", 64'(err_credit), 64'd1);
    repeat (3) next();
    chk("ov_sticky", 64'(err_credit), 64'd1);

    // reset in the middle of a locked packet
    bus.req_valid = 2'b01;
    setf(0, mk(T_DATA, 9));
    next();
    chk("rl_busy", 64'(busy), 64'd1);
    bus.req_valid = 2'b11;
    setf(1, mk(T_SPIKE, 'h66));
    #1 rst_n = 1'b0;
    #1;
    chk("rl_rst_busy", 64'(busy), 64'd0);
    chk("rl_rst_cnt", 64'(credit_cnt), 64'd15);
    chk("rl_rst_err", 64'(err_credit), 64'd0);
    chk("rl_rst_wr", 64'(bus.flit_out_wr), 64'd0);
    bus.req_valid = 2'b10;
    next();
    chk("rl_hold_wr", 64'(bus.flit_out_wr), 64'd0);
    rst_n = 1'b1;
    #1 chk("rl_ready", 64'(bus.req_ready), 64'd2);
    next();
    chk("rl_flit", 64'(bus.flit_out), 64'(mk(T_SPIKE, 'h66)));
    chk("rl_wr", 64'(bus.flit_out_wr), 64'd1);
    bus.req_valid = 2'b00;
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
